// File: rtl/fpu_align_step_seq.sv
// Sequential exponent alignment: shifts the smaller-exponent mantissa right one bit per cycle, folding lost bits into sticky.
// Optional build macro FPU_ALIGN_CLAMP_EN: differences wider than the mantissa collapse to sticky in a single step.
module fpu_align_step_seq #(
   parameter int EW = 10,
   parameter int MW = 27
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [EW-1:0] a_e,
   input  logic [EW-1:0] b_e,
   input  logic [MW-1:0] a_m,
   input  logic [MW-1:0] b_m,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [EW-1:0] a_e_o,
   output logic [EW-1:0] b_e_o,
   output logic [MW-1:0] a_m_o,
   output logic [MW-1:0] b_m_o,
   output logic [EW:0]   sh_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_DONE} state_t;

   localparam logic [EW-1:0] ONE_E = EW'(1);
   localparam logic [EW:0]   ONE_C = (EW+1)'(1);
   localparam logic [EW:0]   MW_C  = (EW+1)'(MW);

   state_t        r_state;
   logic          r_in_ready, r_out_valid;
   logic [EW-1:0] r_a_e, r_b_e;
   logic [MW-1:0] r_a_m, r_b_m;
   logic [EW:0]   r_sh_cnt;

   logic signed [EW:0] w_diff;
   logic [EW:0]        w_abs_diff;
   logic               w_a_gt, w_equal, w_clamp;
   logic [EW-1:0]      w_small_e, w_big_e, w_next_e;
   logic [MW-1:0]      w_small_m, w_shift_m, w_next_m;
   logic [EW:0]        w_next_cnt;

   // Sign-extend by one bit so the difference of two signed exponents cannot overflow.
   assign w_diff     = $signed({r_a_e[EW-1], r_a_e}) - $signed({r_b_e[EW-1], r_b_e});
   assign w_abs_diff = w_diff[EW] ? $unsigned(-w_diff) : $unsigned(w_diff);
   assign w_a_gt     = $signed(r_a_e) > $signed(r_b_e);
   assign w_equal    = (r_a_e == r_b_e);

   assign w_small_e  = w_a_gt ? r_b_e : r_a_e;
   assign w_big_e    = w_a_gt ? r_a_e : r_b_e;
   assign w_small_m  = w_a_gt ? r_b_m : r_a_m;
   assign w_shift_m  = {1'b0, w_small_m[MW-1:2], w_small_m[1] | w_small_m[0]};

`ifdef FPU_ALIGN_CLAMP_EN
   assign w_clamp    = (w_abs_diff > MW_C);
`else
   assign w_clamp    = 1'b0;
`endif

   assign w_next_m   = w_clamp ? {{(MW-1){1'b0}}, |w_small_m} : w_shift_m;
   assign w_next_e   = w_clamp ? w_big_e : w_small_e + ONE_E;
   assign w_next_cnt = r_sh_cnt + (w_clamp ? w_abs_diff : ONE_C);

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_a_e       <= '0;
         r_b_e       <= '0;
         r_a_m       <= '0;
         r_b_m       <= '0;
         r_sh_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a_e      <= a_e;
                  r_b_e      <= b_e;
                  r_a_m      <= a_m;
                  r_b_m      <= b_m;
                  r_sh_cnt   <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               if (w_equal) begin
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_sh_cnt <= w_next_cnt;
                  if (w_a_gt) begin
                     r_b_m <= w_next_m;
                     r_b_e <= w_next_e;
                  end else begin
                     r_a_m <= w_next_m;
                     r_a_e <= w_next_e;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign a_e_o     = r_a_e;
   assign b_e_o     = r_b_e;
   assign a_m_o     = r_a_m;
   assign b_m_o     = r_b_m;
   assign sh_cnt    = r_sh_cnt;

endmodule
